// File: rtl/mel_filter_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : mel_filter_sequencer_if
// Brief    : Mel band output stream (data, band index, valid/ready handshake)
//            between the mel filter sequencer and its downstream consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface mel_filter_sequencer_if #(
    parameter int N_MELS = 40,
    parameter int OUT_W  = 32
);
    logic [OUT_W-1:0]          mel_data_o;
    logic [$clog2(N_MELS)-1:0] mel_idx_o;
    logic                      mel_valid_o;
    logic                      mel_ready_i;

    // Producer side: the sequencer
    modport master (
        output mel_data_o,
        output mel_idx_o,
        output mel_valid_o,
        input  mel_ready_i
    );

    // Consumer side
    modport slave (
        input  mel_data_o,
        input  mel_idx_o,
        input  mel_valid_o,
        output mel_ready_i
    );
endinterface
`default_nettype wire

// File: rtl/mel_filter_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mel_filter_sequencer
// Brief    : Walks a band table, streams power bins and filter weights into an
//            external MAC, and emits one shifted MAC result per mel band.
// Config   : MEL_SEQ_SATURATE_EN - saturate mel output to all-ones when the
//            shifted accumulator overflows OUT_W (default: truncate).
// Revision : 1.0 - initial release
// ============================================================================
module mel_filter_sequencer #(
    parameter int N_BINS  = 257,
    parameter int N_MELS  = 40,
    parameter int POWER_W = 31,
    parameter int COEFF_W = 16,
    parameter int ACCUM_W = 54,
    parameter int OUT_W   = 32,
    parameter int SHIFT   = 16,
    parameter int WADDR_W = 12
) (
    input  wire logic                          clk_i,
    input  wire logic                          reset_i,
    input  wire logic                          start_i,
    output logic                               busy_o,
    output logic                               done_o,
    output logic [$clog2(N_MELS)-1:0]          band_idx_o,
    input  wire logic [$clog2(N_BINS)-1:0]     band_start_i,
    input  wire logic [$clog2(N_BINS+1)-1:0]   band_len_i,
    output logic [$clog2(N_BINS)-1:0]          power_addr_o,
    input  wire logic [POWER_W-1:0]            power_i,
    output logic [WADDR_W-1:0]                 weight_addr_o,
    input  wire logic [COEFF_W-1:0]            weight_i,
    output logic [POWER_W-1:0]                 mac_power_o,
    output logic [COEFF_W-1:0]                 mac_weight_o,
    output logic                               mac_accumulate_o,
    output logic                               mac_clear_o,
    input  wire logic [ACCUM_W-1:0]            mac_accum_i,
    mel_filter_sequencer_if.master             mel_if
);

    localparam int c_ADDR_W = $clog2(N_BINS);
    localparam int c_LEN_W  = $clog2(N_BINS + 1);
    localparam int c_BAND_W = $clog2(N_MELS);
    localparam logic [c_BAND_W-1:0] c_LAST_BAND = c_BAND_W'(N_MELS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_CLEAR   = 3'd2,
        S_RUN     = 3'd3,
        S_DRAIN   = 3'd4,
        S_CAPTURE = 3'd5,
        S_OUTPUT  = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [c_BAND_W-1:0]   r_band;
    logic [WADDR_W-1:0]    r_waddr;
    logic [c_ADDR_W-1:0]   r_start;
    logic [c_LEN_W-1:0]    r_len;
    logic [c_LEN_W-1:0]    r_k;
    logic                  r_issue;
    logic [OUT_W-1:0]      r_mel_data;
    logic [c_BAND_W-1:0]   r_mel_idx;

    logic                  w_run;
    logic                  w_handshake;
    logic [c_LEN_W-1:0]    w_paddr_sum;
    logic [OUT_W-1:0]      w_mel_value;

    // Shifted accumulator reduced to the output width
`ifdef MEL_SEQ_SATURATE_EN
    logic [ACCUM_W-1:0]    w_shifted;
    assign w_shifted   = mac_accum_i >> SHIFT;
    assign w_mel_value = (|w_shifted[ACCUM_W-1:OUT_W]) ? {OUT_W{1'b1}}
                                                       : w_shifted[OUT_W-1:0];
`else
    assign w_mel_value = OUT_W'(mac_accum_i >> SHIFT);
`endif

    assign w_paddr_sum = c_LEN_W'(r_start) + r_k;
    assign w_handshake = (r_state == S_OUTPUT) && mel_if.mel_ready_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and per-state control strobes; reset masks every output
    always_comb begin
        w_next_state = r_state;
        busy_o       = (r_state != S_IDLE);
        done_o       = 1'b0;
        mac_clear_o  = 1'b0;
        w_run        = 1'b0;
        mel_if.mel_valid_o = 1'b0;
        case (r_state)
            S_IDLE:    if (start_i) w_next_state = S_LOAD;
            S_LOAD:    w_next_state = S_CLEAR;
            S_CLEAR: begin
                // Band table data is valid here, one cycle after the LOAD address
                mac_clear_o  = 1'b1;
                w_next_state = (band_len_i != '0) ? S_RUN : S_CAPTURE;
            end
            S_RUN: begin
                w_run = 1'b1;
                if (r_k == r_len - 1'b1) w_next_state = S_DRAIN;
            end
            S_DRAIN:   w_next_state = S_CAPTURE;
            S_CAPTURE: w_next_state = S_OUTPUT;
            S_OUTPUT: begin
                mel_if.mel_valid_o = 1'b1;
                if (mel_if.mel_ready_i)
                    w_next_state = (r_band == c_LAST_BAND) ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                done_o       = 1'b1;
                w_next_state = S_IDLE;
            end
            default:   w_next_state = S_IDLE;
        endcase
        if (reset_i) begin
            busy_o             = 1'b0;
            done_o             = 1'b0;
            mac_clear_o        = 1'b0;
            w_run              = 1'b0;
            mel_if.mel_valid_o = 1'b0;
        end
    end

    // Band, weight-address and run-counter bookkeeping plus result capture
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_band     <= '0;
            r_waddr    <= '0;
            r_start    <= '0;
            r_len      <= '0;
            r_k        <= '0;
            r_issue    <= 1'b0;
            r_mel_data <= '0;
            r_mel_idx  <= '0;
        end else begin
            // Memory data for a RUN issue arrives one cycle later
            r_issue <= (r_state == S_RUN);
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_band  <= '0;
                        r_waddr <= '0;
                    end
                end
                S_CLEAR: begin
                    r_start <= band_start_i;
                    r_len   <= band_len_i;
                    r_k     <= '0;
                end
                S_RUN: begin
                    // Weight address is continuous across bands and wraps
                    r_k     <= r_k + 1'b1;
                    r_waddr <= r_waddr + 1'b1;
                end
                S_CAPTURE: begin
                    r_mel_data <= w_mel_value;
                    r_mel_idx  <= r_band;
                end
                S_OUTPUT: begin
                    if (w_handshake && (r_band != c_LAST_BAND)) r_band <= r_band + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign band_idx_o       = reset_i ? '0 : r_band;
    assign power_addr_o     = w_run ? w_paddr_sum[c_ADDR_W-1:0] : '0;
    assign weight_addr_o    = w_run ? r_waddr : '0;
    assign mac_power_o      = power_i;
    assign mac_weight_o     = weight_i;
    assign mac_accumulate_o = r_issue && !reset_i;
    assign mel_if.mel_data_o = reset_i ? '0 : r_mel_data;
    assign mel_if.mel_idx_o  = reset_i ? '0 : r_mel_idx;

endmodule
`default_nettype wire

// File: doc/mel_filter_sequencer.md
MEL_FILTER_SEQUENCER -- requirements
Module: mel_filter_sequencer

Interface
REQ-001 SHALL have parameters: N_BINS, default 257, FFT power bins per frame; N_MELS, default 40, mel bands per frame; POWER_W, default 31, power sample width; COEFF_W, default 16, filter weight width; ACCUM_W, default 54, MAC accumulator width; OUT_W, default 32, mel output width; SHIFT, default 16, right-shift applied to the accumulator; WADDR_W, default 12, weight ROM address width.
REQ-002 SHALL have ports, clock and reset first: clk_i in 1, the single clock; reset_i in 1, synchronous active-high reset.
REQ-003 SHALL have control ports: start_i in 1, frame start pulse; busy_o out 1, frame in progress; done_o out 1, frame complete pulse.
REQ-004 SHALL have band table ports: band_idx_o out clog2(N_MELS), table address; band_start_i in clog2(N_BINS), first bin of the band; band_len_i in clog2(N_BINS+1), bin count of the band; read latency is 1 cycle.
REQ-005 SHALL have power buffer ports: power_addr_o out clog2(N_BINS); power_i in POWER_W; read latency is 1 cycle.
REQ-006 SHALL have weight ROM ports: weight_addr_o out WADDR_W; weight_i in COEFF_W; read latency is 1 cycle.
REQ-007 SHALL have MAC ports: mac_power_o out POWER_W; mac_weight_o out COEFF_W; mac_accumulate_o out 1; mac_clear_o out 1; mac_accum_i in ACCUM_W. The MAC registers accumulate/clear on the next edge.
REQ-008 SHALL have output ports: mel_data_o out OUT_W; mel_idx_o out clog2(N_MELS); mel_valid_o out 1; mel_ready_i in 1.

Function
REQ-009 SHALL implement FSM states IDLE, LOAD, CLEAR, RUN, DRAIN, CAPTURE, OUTPUT, DONE.
REQ-010 IDLE SHALL go to LOAD on start_i=1, with band=0 and weight address=0. start_i SHALL be ignored in every other state.
REQ-011 LOAD SHALL drive band_idx_o=band for one cycle, then go to CLEAR, registering band_start_i and band_len_i.
REQ-012 CLEAR SHALL assert mac_clear_o for exactly one cycle. The next state SHALL be RUN if len>0, else CAPTURE.
REQ-013 RUN SHALL last len cycles. In cycle k it SHALL issue power_addr_o=start+k and weight_addr_o=waddr, then increment waddr.
REQ-014 mac_accumulate_o SHALL be asserted in the cycle after each RUN issue cycle. In that cycle mac_power_o=power_i and mac_weight_o=weight_i, passed combinationally.
REQ-015 DRAIN SHALL be one cycle and carry the final accumulate. CAPTURE SHALL follow one cycle later so that mac_accum_i includes the last product.
REQ-016 CAPTURE SHALL register mel_data_o from mac_accum_i>>SHIFT and set mel_idx_o=band.
REQ-017 OUTPUT SHALL hold mel_valid_o=1 with mel_data_o and mel_idx_o stable until mel_ready_i=1.
REQ-018 On the OUTPUT handshake, the FSM SHALL go to LOAD with band+1 if band<N_MELS-1, else to DONE.
REQ-019 DONE SHALL pulse done_o for one cycle, then go to IDLE.
REQ-020 The weight address SHALL run continuously across bands, so total ROM use equals the sum of len. It SHALL wrap modulo 2^WADDR_W.
REQ-021 A zero-length band SHALL output 0 and SHALL never assert mac_accumulate_o.
REQ-022 mac_clear_o and mac_accumulate_o SHALL never be asserted in the same cycle.
REQ-023 mac_accumulate_o SHALL be 0 outside the accumulate cycles defined above, so the MAC value holds during backpressure.
REQ-024 busy_o SHALL be 1 in every state except IDLE.
REQ-025 A start_i arriving in the same cycle as the DONE pulse SHALL be ignored.
REQ-026 The bench SHALL drive start+len<=N_BINS. No range check is performed on it.

Reset
REQ-027 reset_i SHALL force IDLE from any state, including mid-frame.
REQ-028 While reset_i=1 and on the following cycle: busy_o, done_o, mel_valid_o, mac_accumulate_o and mac_clear_o SHALL be 0; mel_data_o, mel_idx_o, band_idx_o, power_addr_o and weight_addr_o SHALL be 0.
REQ-029 A partial band in progress at reset SHALL be discarded with no output.

Configuration
REQ-030 Macro MEL_SEQ_SATURATE_EN defined: if any bit of mac_accum_i>>SHIFT above OUT_W-1 is set, mel_data_o SHALL be all-ones.
REQ-031 Macro MEL_SEQ_SATURATE_EN undefined: mel_data_o SHALL be the low OUT_W bits of mac_accum_i>>SHIFT (truncation).

Verification
REQ-032 Scenario: N_MELS=2, bands (0,3) and (3,2), all power=65536, all weights=1, SHIFT=16, ready=1 -> two outputs: 3 at idx 0, then 2 at idx 1; then done_o pulses once; weight addresses 0..4 are issued.
REQ-033 Scenario: band length 0 -> mel_data_o=0; no accumulate pulse is seen; the next band's weight address is unchanged.
REQ-034 Scenario: mel_ready_i held 0 for 10 cycles at OUTPUT -> mel_valid_o stays 1; data is stable; mac_accumulate_o stays 0; the output is accepted on the first ready.
REQ-035 Scenario: reset_i pulsed during RUN of band 1 -> next cycle busy_o=0 and mel_valid_o=0; a fresh start yields band 0 correctly.
REQ-036 Scenario: power=2^31-1, weight=65535, len=257, SHIFT=0, OUT_W=32 -> with the macro defined, output 0xFFFFFFFF; with it undefined, output the low 32 bits of the exact sum.
REQ-037 Scenario: start_i pulsed while busy -> ignored; exactly N_MELS outputs and one done_o are produced.
